serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues operations and the slave (the subtractor) returns results.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flop; the result is published only on completion.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   s
);

  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic             w_ai;
  logic             w_bi;
  logic             w_di;
  logic             w_bo;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_next;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    w_ai       = r_a_sh[0];
    w_bi       = r_b_sh[0];
    w_di       = w_ai ^ w_bi ^ r_br;
    w_bo       = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
    w_res_next = {w_di, r_res[WIDTH-1:1]};
    // On the last bit the operand LSBs are the original sign bits, so no extra copy is kept.
    w_ovf      = (w_ai != w_bi) & (w_res_next[WIDTH-1] != w_ai);
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (s.start) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (s.start) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_a_sh <= s.a;
        r_b_sh <= s.b;
        r_br   <= s.bin;
        r_cnt  <= '0;
        r_res  <= '0;
      end else if (r_state == SHIFT) begin
        r_a_sh <= r_a_sh >> 1;
        r_b_sh <= r_b_sh >> 1;
        r_br   <= w_bo;
        r_cnt  <= r_cnt + 1'b1;
        r_res  <= w_res_next;
        if (w_last) begin
          r_diff <= w_res_next;
          r_bout <= w_bo;
          r_ovf  <= w_ovf;
        end
      end
    end
  end

  assign s.busy = w_busy;
  assign s.done = w_done;
  assign s.diff = r_diff;
  assign s.bout = r_bout;
  assign s.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive bench for serial_subtractor at WIDTH=4.
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(WIDTH)) s_if ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .s   (s_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: 5-bit unsigned difference and signed-range overflow.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input logic bin);
    logic [4:0] u;
    int         sd;
    logic       o;
    u  = {1'b0, a} - {1'b0, b} - {4'b0, bin};
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    o  = (sd > 7) || (sd < -8);
    return {o, u};
  endfunction

  // Issue one operation and wait for done; reports cycles to done and busy cycles seen.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output int lat, output int nbusy);
    s_if.a     = a;
    s_if.b     = b;
    s_if.bin   = bin;
    s_if.start = 1'b1;
    lat   = 0;
    nbusy = 0;
    do begin
      tick();
      s_if.start = 1'b0;
      lat++;
      if (s_if.busy) nbusy++;
    end while (!s_if.done && lat < 20);
  endtask

  task automatic test_reset();
    s_if.start = 1'b0;
    s_if.a     = '0;
    s_if.b     = '0;
    s_if.bin   = 1'b0;
    rst        = 1'b1;
    tick();
    tick();
    checks++;
    if ({s_if.busy, s_if.done, s_if.diff, s_if.bout, s_if.ovf} !== 8'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b diff=%b bout=%b ovf=%b, want all 0",
               s_if.busy, s_if.done, s_if.diff, s_if.bout, s_if.ovf);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (s_if.busy !== 1'b0 || s_if.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", s_if.busy, s_if.done);
    end
  endtask

  task automatic test_directed();
    // a, b, bin, expected diff, bout, ovf (hand computed)
    logic [3:0] va   [5] = '{4'b0111, 4'b0011, 4'b0000, 4'b0111, 4'b1000};
    logic [3:0] vb   [5] = '{4'b0011, 4'b0111, 4'b0000, 4'b1000, 4'b0001};
    logic       vbin [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] ed   [5] = '{4'b0100, 4'b1100, 4'b1111, 4'b1111, 4'b0111};
    logic       eb   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       eo   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, nbusy;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vbin[i], lat, nbusy);
      checks++;
      if (lat != WIDTH + 1 || nbusy != WIDTH) begin
        errors++;
        $display("FAIL directed_latency[%0d]: done after %0d cycles busy %0d, want %0d busy %0d",
                 i, lat, nbusy, WIDTH + 1, WIDTH);
      end
      checks++;
      if ({s_if.diff, s_if.bout, s_if.ovf} !== {ed[i], eb[i], eo[i]}) begin
        errors++;
        $display("FAIL directed_result[%0d]: diff=%b bout=%b ovf=%b, want diff=%b bout=%b ovf=%b",
                 i, s_if.diff, s_if.bout, s_if.ovf, ed[i], eb[i], eo[i]);
      end
      tick();
      checks++;
      if (s_if.done !== 1'b0 || {s_if.diff, s_if.bout, s_if.ovf} !== {ed[i], eb[i], eo[i]}) begin
        errors++;
        $display("FAIL directed_hold[%0d]: done=%b diff=%b bout=%b ovf=%b, want done=0 and held result",
                 i, s_if.done, s_if.diff, s_if.bout, s_if.ovf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va   [4] = '{4'b0101, 4'b1001, 4'b0000, 4'b1111};
    logic [3:0] vb   [4] = '{4'b0010, 4'b0110, 4'b0001, 4'b1111};
    logic       vbin [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [5:0] exp_r;
    int n;
    for (int k = 0; k < 4; k++) begin
      s_if.a     = va[k];
      s_if.b     = vb[k];
      s_if.bin   = vbin[k];
      s_if.start = 1'b1;
      n = 0;
      do begin
        tick();
        n++;
        // start stays high and operands churn while busy; neither may disturb the operation
        if (s_if.busy) begin
          s_if.a   = 4'($urandom);
          s_if.b   = 4'($urandom);
          s_if.bin = 1'($urandom);
        end
      end while (!s_if.done && n < 20);
      exp_r = model(va[k], vb[k], vbin[k]);
      checks++;
      if (n != WIDTH + 1) begin
        errors++;
        $display("FAIL b2b_period[%0d]: done after %0d cycles, want %0d", k, n, WIDTH + 1);
      end
      checks++;
      if ({s_if.ovf, s_if.bout, s_if.diff} !== exp_r) begin
        errors++;
        $display("FAIL b2b_result[%0d]: ovf=%b bout=%b diff=%b, want ovf=%b bout=%b diff=%b",
                 k, s_if.ovf, s_if.bout, s_if.diff, exp_r[5], exp_r[4], exp_r[3:0]);
      end
    end
    s_if.start = 1'b0;
    tick();
    checks++;
    if (s_if.busy !== 1'b0 || s_if.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", s_if.busy, s_if.done);
    end
  endtask

  task automatic test_reset_abort();
    int lat, nbusy;
    bit saw_done;
    // leave a nonzero result so the reset clear is observable
    run_op(4'b0000, 4'b0001, 1'b0, lat, nbusy);
    checks++;
    if ({s_if.diff, s_if.bout} !== 5'b11111) begin
      errors++;
      $display("FAIL abort_setup: diff=%b bout=%b, want 1111 1", s_if.diff, s_if.bout);
    end
    tick();
    s_if.a     = 4'b0111;
    s_if.b     = 4'b0011;
    s_if.bin   = 1'b0;
    s_if.start = 1'b1;
    tick();
    s_if.start = 1'b0;
    tick();
    checks++;
    if (s_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: busy=%b, want 1", s_if.busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({s_if.busy, s_if.done, s_if.diff, s_if.bout, s_if.ovf} !== 8'b0) begin
      errors++;
      $display("FAIL abort_clear: busy=%b done=%b diff=%b bout=%b ovf=%b, want all 0",
               s_if.busy, s_if.done, s_if.diff, s_if.bout, s_if.ovf);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_if.done || s_if.busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_no_done: activity seen after abort, want none");
    end
    run_op(4'b1010, 4'b0011, 1'b1, lat, nbusy);
    checks++;
    if ({s_if.diff, s_if.bout, s_if.ovf} !== {4'b0110, 1'b0, 1'b1} || lat != WIDTH + 1) begin
      errors++;
      $display("FAIL abort_recover: diff=%b bout=%b ovf=%b lat=%0d, want 0110 0 1 lat %0d",
               s_if.diff, s_if.bout, s_if.ovf, lat, WIDTH + 1);
    end
  endtask

  task automatic test_exhaustive();
    int lat, nbusy;
    logic [5:0] exp_r;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          run_op(4'(ia), 4'(ib), 1'(ic), lat, nbusy);
          exp_r = model(4'(ia), 4'(ib), 1'(ic));
          checks++;
          if ({s_if.ovf, s_if.bout, s_if.diff} !== exp_r || lat != WIDTH + 1 || nbusy != WIDTH) begin
            errors++;
            $display("FAIL exhaustive a=%0d b=%0d bin=%0d: ovf=%b bout=%b diff=%b lat=%0d busy=%0d, want ovf=%b bout=%b diff=%b lat=%0d busy=%0d",
                     ia, ib, ic, s_if.ovf, s_if.bout, s_if.diff, lat, nbusy,
                     exp_r[5], exp_r[4], exp_r[3:0], WIDTH + 1, WIDTH);
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
